// File: rtl/btn_ctrl.sv
// Front-panel button conditioner: 2-flop synchronisers, per-button debounce FSMs,
// toggled go/up levels, single-cycle event pulses and a long-press clear on go.
module btn_ctrl #(
  parameter int DB_CYCLES   = 1000000,
  parameter int HOLD_CYCLES = 200000000,
  parameter int CNT_W       = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_go,
  input  logic btn_up,
  input  logic btn_clr,
  output logic go,
  output logic up,
  output logic go_pulse,
  output logic up_pulse,
  output logic clr
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam int NBTN = 3;
  localparam int GO_IDX = 0;
  localparam int UP_IDX = 1;
  localparam int CLR_IDX = 2;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  // One below saturation: the edge that lands on HOLD_LAST is the one that fires clr.
  localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(HOLD_CYCLES - 2);

  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  sync_p0;
  logic [NBTN-1:0]  sync_p1;
  state_t           state [NBTN];
  logic [CNT_W-1:0] cnt   [NBTN];
  logic [CNT_W-1:0] hold;
  logic [NBTN-1:0]  accept;
  logic             hold_exp;

  assign raw = {btn_clr, btn_up, btn_go};

  always_comb begin
    accept = '0;
    for (int i = 0; i < NBTN; i++) begin
      accept[i] = (state[i] == PRESS_WAIT) && sync_p1[i] && (cnt[i] == DB_LAST);
    end
    hold_exp = (state[GO_IDX] == PRESSED) && (hold == HOLD_FIRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      for (int i = 0; i < NBTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
      hold     <= '0;
      go       <= 1'b0;
      up       <= 1'b1;
      go_pulse <= 1'b0;
      up_pulse <= 1'b0;
      clr      <= 1'b0;
    end else begin
      // Stage p0 -> p1: metastability filter on the raw buttons
      sync_p0 <= raw;
      sync_p1 <= sync_p0;

      // Debounce: any bounce inside a wait state falls back to that wait's origin
      for (int i = 0; i < NBTN; i++) begin
        case (state[i])
          IDLE: begin
            if (sync_p1[i]) begin
              state[i] <= PRESS_WAIT;
              cnt[i]   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!sync_p1[i])            state[i] <= IDLE;
            else if (cnt[i] == DB_LAST) state[i] <= PRESSED;
            else                        cnt[i]   <= cnt[i] + CNT_ONE;
          end
          PRESSED: begin
            if (!sync_p1[i]) begin
              state[i] <= RELEASE_WAIT;
              cnt[i]   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (sync_p1[i])             state[i] <= PRESSED;
            else if (cnt[i] == DB_LAST) state[i] <= IDLE;
            else                        cnt[i]   <= cnt[i] + CNT_ONE;
          end
          default: state[i] <= IDLE;
        endcase
      end

      // Long-press timer saturates so a held button clears only once
      if (state[GO_IDX] != PRESSED) hold <= '0;
      else if (hold != HOLD_LAST)   hold <= hold + CNT_ONE;

      go_pulse <= accept[GO_IDX];
      up_pulse <= accept[UP_IDX];
      clr      <= accept[CLR_IDX] | hold_exp;

      if (hold_exp)            go <= 1'b0;
      else if (accept[GO_IDX]) go <= ~go;

      if (accept[UP_IDX]) up <= ~up;
    end
  end

endmodule

// File: tb/tb_btn_ctrl.sv
// Directed bench for btn_ctrl with DB_CYCLES=8, HOLD_CYCLES=64.
module tb_btn_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_go, btn_up, btn_clr;
  logic go, up, go_pulse, up_pulse, clr;

  int tests = 0;
  int fails = 0;

  btn_ctrl #(.DB_CYCLES(8), .HOLD_CYCLES(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .btn_go(btn_go), .btn_up(btn_up), .btn_clr(btn_clr),
    .go(go), .up(up), .go_pulse(go_pulse), .up_pulse(up_pulse), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    tests++;
    if ({go, up, go_pulse, up_pulse, clr} !== 5'b01000) begin
      fails++;
      $display("FAIL reset_state: got %b want 01000", {go, up, go_pulse, up_pulse, clr});
    end
  endtask

  // btn_go held 20 cycles: one pulse at cycle 11, go 0->1, no pulse on release.
  task automatic test_clean_press();
    int n = 0, first = -1;
    logic go10 = 1'b0, go11 = 1'b0;
    btn_go = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (go_pulse) begin n++; if (first < 0) first = i; end
      if (i == 10) go10 = go;
      if (i == 11) go11 = go;
      if (i == 20) btn_go = 1'b0;
    end
    tests++; if (n !== 1) begin fails++; $display("FAIL clean_pulse_count: got %0d want 1", n); end
    tests++; if (first !== 11) begin fails++; $display("FAIL clean_pulse_cycle: got %0d want 11", first); end
    tests++; if ({go10, go11} !== 2'b01) begin fails++; $display("FAIL clean_go_toggle: got %b want 01", {go10, go11}); end
    tests++; if (go !== 1'b1) begin fails++; $display("FAIL clean_go_final: got %b want 1", go); end
  endtask

  // btn_up bounces with 3-cycle runs until cycle 30, then steady: one pulse at 41.
  task automatic test_bounce();
    int n = 0, first = -1;
    btn_up = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (up_pulse) begin n++; if (first < 0) first = i; end
      if (i < 30)       btn_up = ((i / 3) % 2 == 0);
      else if (i < 60)  btn_up = 1'b1;
      else              btn_up = 1'b0;
    end
    tests++; if (n !== 1) begin fails++; $display("FAIL bounce_pulse_count: got %0d want 1", n); end
    tests++; if (first !== 41) begin fails++; $display("FAIL bounce_pulse_cycle: got %0d want 41", first); end
    tests++; if (up !== 1'b0) begin fails++; $display("FAIL bounce_up_level: got %b want 0", up); end
    tests++; if (go !== 1'b1) begin fails++; $display("FAIL bounce_go_untouched: got %b want 1", go); end
  endtask

  // Release with glitches shorter than DB_CYCLES: go toggles once (1->0).
  task automatic test_release_bounce();
    int n = 0, first = -1;
    logic [0:11] tail = 12'b000100001100;
    btn_go = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (go_pulse) begin n++; if (first < 0) first = i; end
      if (i >= 20 && i < 32) btn_go = tail[i-20];
      else if (i >= 32)      btn_go = 1'b0;
    end
    tests++; if (n !== 1) begin fails++; $display("FAIL relbounce_pulse_count: got %0d want 1", n); end
    tests++; if (first !== 11) begin fails++; $display("FAIL relbounce_pulse_cycle: got %0d want 11", first); end
    tests++; if (go !== 1'b0) begin fails++; $display("FAIL relbounce_go_level: got %b want 0", go); end
  endtask

  // btn_go held 100 cycles: toggle at 11, clr at 10+64=74, go forced low after.
  task automatic test_long_press();
    int n_clr = 0, c_clr = -1, first = -1;
    logic go50 = 1'b0;
    btn_go = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      @(posedge clk); #1;
      if (clr) begin n_clr++; if (c_clr < 0) c_clr = i; end
      if (go_pulse && first < 0) first = i;
      if (i == 50) go50 = go;
      if (i == 100) btn_go = 1'b0;
    end
    tests++; if (first !== 11) begin fails++; $display("FAIL long_go_pulse_cycle: got %0d want 11", first); end
    tests++; if (go50 !== 1'b1) begin fails++; $display("FAIL long_go_mid: got %b want 1", go50); end
    tests++; if (n_clr !== 1) begin fails++; $display("FAIL long_clr_count: got %0d want 1", n_clr); end
    tests++; if (c_clr !== 74) begin fails++; $display("FAIL long_clr_cycle: got %0d want 74", c_clr); end
    tests++; if (go !== 1'b0) begin fails++; $display("FAIL long_go_final: got %b want 0", go); end
    tests++; if (up !== 1'b0) begin fails++; $display("FAIL long_up_untouched: got %b want 0", up); end
  endtask

  // btn_clr and btn_up together: both pulses at cycle 11, up 0->1, go stays 0.
  task automatic test_simultaneous();
    int c_clr = -1, c_up = -1, n_clr = 0, n_up = 0;
    btn_clr = 1'b1;
    btn_up  = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (clr)      begin n_clr++; if (c_clr < 0) c_clr = i; end
      if (up_pulse) begin n_up++;  if (c_up  < 0) c_up  = i; end
      if (i == 20) begin btn_clr = 1'b0; btn_up = 1'b0; end
    end
    tests++; if (c_clr !== 11 || n_clr !== 1) begin fails++; $display("FAIL simul_clr: got cycle %0d count %0d want 11/1", c_clr, n_clr); end
    tests++; if (c_up !== 11 || n_up !== 1) begin fails++; $display("FAIL simul_up_pulse: got cycle %0d count %0d want 11/1", c_up, n_up); end
    tests++; if (up !== 1'b1) begin fails++; $display("FAIL simul_up_level: got %b want 1", up); end
    tests++; if (go !== 1'b0) begin fails++; $display("FAIL simul_go_level: got %b want 0", go); end
  endtask

  // Reset while go=1 and up=0, then re-qualification of a still-held btn_go.
  task automatic test_reset_mid();
    int first = -1;
    btn_up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 20) btn_up = 1'b0;
    end
    btn_go = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
    end
    tests++; if ({go, up} !== 2'b10) begin fails++; $display("FAIL premid_levels: got %b want 10", {go, up}); end
    rst = 1'b1;
    #1;
    tests++;
    if ({go, up, go_pulse, up_pulse, clr} !== 5'b01000) begin
      fails++;
      $display("FAIL async_reset: got %b want 01000", {go, up, go_pulse, up_pulse, clr});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (go_pulse && first < 0) first = i;
    end
    tests++; if (first !== 11) begin fails++; $display("FAIL requalify_pulse_cycle: got %0d want 11", first); end
    tests++; if (go !== 1'b1) begin fails++; $display("FAIL requalify_go: got %b want 1", go); end
    btn_go = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_go = 1'b0;
    btn_up = 1'b0;
    btn_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_ctrl.md
Name: btn_ctrl

Overview:
Upstream conditioning stage for the stopwatch display path. Takes three raw, bouncing front-panel buttons and turns them into clean control signals: a synchronised, debounced run level (go), a direction level (up), and single-cycle event pulses. The go/up levels drive the stopwatch counter directly. The clr pulse clears the counter; it is also raised on a long press of the run button.

Parameters:
DB_CYCLES, 1000000, stable-input cycles required to accept a press or release (10 ms at 100 MHz); minimum 2
HOLD_CYCLES, 200000000, cycles the run button must stay accepted-pressed to fire clr (2 s at 100 MHz); must exceed DB_CYCLES
CNT_W, 28, width of the internal counters; must hold max(DB_CYCLES, HOLD_CYCLES)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
btn_go  in  1  raw run/stop button, active-high, asynchronous to clk
btn_up  in  1  raw count-direction button, active-high, asynchronous
btn_clr  in  1  raw clear button, active-high, asynchronous
go  out  1  run level; toggles on each accepted btn_go press
up  out  1  direction level (1 = count up); toggles on each accepted btn_up press
go_pulse  out  1  one-cycle pulse on each accepted btn_go press
up_pulse  out  1  one-cycle pulse on each accepted btn_up press
clr  out  1  one-cycle clear pulse

Behaviour:
- Reset (async assert, clocked release): all synchronisers 0, all FSMs IDLE, counters 0, go=0, up=1, go_pulse=up_pulse=clr=0.
- Each raw input passes through a 2-flop synchroniser. The FSMs see only the second-flop value (s).
- Each button has its own FSM and DB_CYCLES counter, structurally identical.
  - IDLE: s=1 -> PRESS_WAIT, counter=0.
  - PRESS_WAIT: s=0 -> IDLE. Otherwise the counter increments; when counter==DB_CYCLES-1 with s=1 -> PRESSED and a one-cycle accept event fires.
  - PRESSED: s=0 -> RELEASE_WAIT, counter=0.
  - RELEASE_WAIT: s=1 -> PRESSED, with no new accept event. Otherwise the counter increments; at DB_CYCLES-1 with s=0 -> IDLE.
- Any bounce inside a wait state restarts the qualification from that state's origin. Exactly one accept event is produced per debounced press.
- Latency: raw rising edge held stable -> accept event = 2 (sync) + DB_CYCLES cycles. go_pulse/up_pulse are registered from the accept event: asserted for exactly 1 cycle, 1 cycle after accept. go and up toggle on the same edge their pulse rises.
- Clear:
  - clr is 1 cycle, 1 cycle after a btn_clr accept event.
  - The hold counter runs while the go FSM is in PRESSED. When it reaches HOLD_CYCLES-1: clr pulses once, go is forced to 0, and the counter saturates, so there is no repeat until release.
  - The hold counter resets on leaving PRESSED.
  - A long press still produces its normal go toggle at acceptance. The forced go=0 overrides it later.
- Simultaneous events:
  - btn_clr accept and hold-expiry in the same cycle -> a single 1-cycle clr.
  - go toggle and hold-forced clear in the same cycle -> go=0 (clear wins).
  - The buttons are independent; simultaneous go/up accepts toggle both.
- clr does not alter up.
- rst mid-press: everything returns to reset values immediately. A button still held at reset release must be re-qualified from IDLE and does toggle once DB_CYCLES elapse.
- Counter width: CNT_W bits unsigned, no wrap. Comparisons use equality with parameter-1 and hold at saturation.

Test Plan:
- Reset: DB_CYCLES=8, HOLD_CYCLES=64; assert rst mid-simulation -> go=0, up=1, pulses=0 asynchronously, before the next clk edge.
- Clean press: btn_go high for 20 cycles then low -> one go_pulse at cycle 2+8+1=11 after the edge; go 0->1; release produces no pulse.
- Bounce: btn_up toggling every 3 cycles for 30 cycles, then steady high -> no up_pulse during the bounce; exactly one pulse 11 cycles after it settles; up 1->0.
- Release bounce: hold btn_go, then bounce on release with glitches shorter than 8 cycles -> no second go_pulse; go toggled exactly once.
- Long press: btn_go high 100 cycles -> go_pulse, go=1, then clr pulse 64 cycles after acceptance; go=0 thereafter; only one clr.
- Simultaneous: btn_clr and btn_up pressed on the same cycle -> clr and up_pulse both pulse on the same cycle 11; up toggles; go unchanged.
